// File: rtl/goofy_pkg.sv
// Shared definitions for the goofy_seq instruction sequencer.
// Optional feature macro: GOOFY_SINGLE_STEP_EN (adds PAUSE state and step input).
package goofy_pkg;

    localparam int unsigned DEF_ADDR_W  = 8;
    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned DEF_NUM_OPS = 2;
    localparam int unsigned DEF_MC_W    = 3;

    // The HALT opcode has every data bit set to this value (all-ones at any DATA_W)
    localparam logic HALT_OP_BIT = 1'b1;

`ifdef GOOFY_SINGLE_STEP_EN
    localparam int unsigned STATE_W = 3;
    typedef enum logic [STATE_W-1:0] {
        StFetchOp  = 3'd0,
        StFetchArg = 3'd1,
        StExec     = 3'd2,
        StHalt     = 3'd3,
        StPause    = 3'd4
    } state_e;
`else
    localparam int unsigned STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {
        StFetchOp  = 2'd0,
        StFetchArg = 2'd1,
        StExec     = 2'd2,
        StHalt     = 2'd3
    } state_e;
`endif

endpackage

// File: rtl/goofy_fetch.sv
// Memory read handshake: holds request and address stable until accepted.
// Optional feature macro: GOOFY_SINGLE_STEP_EN (not used in this file).
module goofy_fetch #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_nxt,
    input  logic [ADDR_W-1:0] i_addr_nxt,
    input  logic              i_ack,
    output logic              o_req,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_hit
);

    logic              r_req;
    logic [ADDR_W-1:0] r_addr;
    logic              w_hit;

    // An ack only counts while a request is actually outstanding
    assign w_hit = r_req & i_ack;

    // Hold req/addr while waiting; take the next request when idle or on accept
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_req  <= 1'b0;
            r_addr <= '0;
        end else if (!r_req || w_hit) begin
            r_req <= i_req_nxt;
            if (i_req_nxt) begin
                r_addr <= i_addr_nxt;
            end
        end
    end

    assign o_req  = r_req;
    assign o_addr = r_addr;
    assign o_hit  = w_hit;

endmodule

// File: rtl/goofy_seq.sv
// goofy_seq: fetch opcode + operands, step microcode, branch or advance rip.
// Optional feature macro: GOOFY_SINGLE_STEP_EN (step input, PAUSE after each EXEC).
module goofy_seq
    import goofy_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned NUM_OPS = DEF_NUM_OPS,
    parameter int unsigned MC_W    = DEF_MC_W
) (
    input  logic                                              clk,
    input  logic                                              res,
`ifdef GOOFY_SINGLE_STEP_EN
    input  logic                                              step,
`endif
    output logic                                              mem_req,
    output logic [ADDR_W-1:0]                                 mem_addr,
    input  logic                                              mem_ack,
    input  logic [DATA_W-1:0]                                 mem_rdata,
    output logic [DATA_W+MC_W-1:0]                            mc_addr,
    input  logic                                              mc_finish,
    input  logic                                              br_take,
    input  logic [ADDR_W-1:0]                                 br_target,
    output logic [ADDR_W-1:0]                                 rip,
    output logic [DATA_W-1:0]                                 iop,
    // NUM_OPS=0 keeps a minimum 1-bit width so the port stays legal
    output logic [(NUM_OPS == 0 ? 1 : NUM_OPS*DATA_W)-1:0]    ops,
    output logic [STATE_W-1:0]                                state,
    output logic                                              hlt
);

    localparam int unsigned OPS_W = (NUM_OPS == 0) ? 1 : NUM_OPS * DATA_W;
    localparam int unsigned IDX_W = 2;

    state_e             r_state;
    logic [ADDR_W-1:0]  r_rip;
    logic [DATA_W-1:0]  r_iop;
    logic [OPS_W-1:0]   r_ops;
    logic [MC_W-1:0]    r_mc;
    logic [IDX_W-1:0]   r_idx;
    logic               r_hlt;

    logic               w_hit;
    logic               w_req_nxt;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic               w_halt_op;
    logic               w_last_arg;
    logic               w_exec_end;
    logic [ADDR_W-1:0]  w_arg_addr;
    logic [ADDR_W-1:0]  w_rip_end;

    assign w_halt_op  = (mem_rdata == {DATA_W{HALT_OP_BIT}});
    assign w_last_arg = (r_idx == IDX_W'(NUM_OPS - 1));
    assign w_exec_end = (r_state == StExec) && (mc_finish || (r_mc == '1));
    assign w_arg_addr = r_rip + ADDR_W'(r_idx) + ADDR_W'(1);
    assign w_rip_end  = br_take ? br_target : (r_rip + ADDR_W'(NUM_OPS + 1));

    // Next request seen by the fetcher; lets the address advance right after each ack
    always_comb begin
        w_req_nxt  = 1'b0;
        w_addr_nxt = r_rip;
        case (r_state)
            StFetchOp: begin
                if (!w_hit) begin
                    w_req_nxt = 1'b1;
                end else if (!w_halt_op && (NUM_OPS != 0)) begin
                    w_req_nxt  = 1'b1;
                    w_addr_nxt = r_rip + ADDR_W'(1);
                end
            end
            StFetchArg: begin
                w_req_nxt  = !(w_hit && w_last_arg);
                w_addr_nxt = w_hit ? (w_arg_addr + ADDR_W'(1)) : w_arg_addr;
            end
`ifndef GOOFY_SINGLE_STEP_EN
            StExec: begin
                if (w_exec_end) begin
                    w_req_nxt  = 1'b1;
                    w_addr_nxt = w_rip_end;
                end
            end
`endif
            default: ;
        endcase
    end

    goofy_fetch #(
        .ADDR_W (ADDR_W)
    ) u_fetch (
        .i_clk      (clk),
        .i_rst_n    (res),
        .i_req_nxt  (w_req_nxt),
        .i_addr_nxt (w_addr_nxt),
        .i_ack      (mem_ack),
        .o_req      (mem_req),
        .o_addr     (mem_addr),
        .o_hit      (w_hit)
    );

    // Sequencer FSM: capture fetched words, run microcode, update rip
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state <= StFetchOp;
            r_rip   <= '0;
            r_iop   <= '0;
            r_ops   <= '0;
            r_mc    <= '0;
            r_idx   <= '0;
            r_hlt   <= 1'b0;
        end else begin
            case (r_state)
                StFetchOp: begin
                    if (w_hit) begin
                        r_iop <= mem_rdata;
                        r_mc  <= '0;
                        r_idx <= '0;
                        if (w_halt_op) begin
                            r_state <= StHalt;
                            r_hlt   <= 1'b1;
                        end else if (NUM_OPS != 0) begin
                            r_state <= StFetchArg;
                        end else begin
                            r_state <= StExec;
                        end
                    end
                end
                StFetchArg: begin
                    if (w_hit) begin
                        for (int k = 0; k < NUM_OPS; k++) begin
                            if (r_idx == IDX_W'(k)) begin
                                r_ops[k*DATA_W +: DATA_W] <= mem_rdata;
                            end
                        end
                        if (w_last_arg) begin
                            r_state <= StExec;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                StExec: begin
                    r_mc <= r_mc + MC_W'(1);
                    if (w_exec_end) begin
                        r_rip <= w_rip_end;
`ifdef GOOFY_SINGLE_STEP_EN
                        r_state <= StPause;
`else
                        r_state <= StFetchOp;
`endif
                    end
                end
`ifdef GOOFY_SINGLE_STEP_EN
                StPause: begin
                    if (step) begin
                        r_state <= StFetchOp;
                    end
                end
`endif
                StHalt: ;
                default: r_state <= StFetchOp;
            endcase
        end
    end

    assign mc_addr = {r_iop, r_mc};
    assign rip     = r_rip;
    assign iop     = r_iop;
    assign ops     = r_ops;
    assign state   = r_state;
    assign hlt     = r_hlt;

endmodule

// File: doc/goofy_seq.md
GOOFY_SEQ -- requirements
Module: goofy_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning the program-counter (rip) and memory-address width.
REQ-002 SHALL have parameter DATA_W, default 8, meaning the opcode, operand and memory data width.
REQ-003 SHALL have parameter NUM_OPS, default 2, range 0..4, meaning the operand words fetched after each opcode.
REQ-004 SHALL have parameter MC_W, default 3, meaning the microcode step counter width; steps per instruction = 2**MC_W.
REQ-005 SHALL have port clk  in  1  system clock; one clock, all state rising-edge.
REQ-006 SHALL have port res  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port mem_req  out  1  read request; mem_addr  out  ADDR_W  read address.
REQ-008 SHALL have port mem_ack  in  1  read accept; mem_rdata  in  DATA_W  read data valid on ack.
REQ-009 SHALL have port mc_addr  out  DATA_W+MC_W  microcode ROM address {iop, mc_counter}.
REQ-010 SHALL have port mc_finish  in  1  last micro-step of instruction; br_take  in  1  branch request; br_target  in  ADDR_W  branch address.
REQ-011 SHALL have ports rip  out  ADDR_W; iop  out  DATA_W; ops  out  NUM_OPS*DATA_W (op0 in LSBs); state  out  2; hlt  out  1.

Function
REQ-012 SHALL implement states FETCH_OP=0, FETCH_ARG=1, EXEC=2, HALT=3, visible on state.
REQ-013 FETCH_OP SHALL assert mem_req with mem_addr=rip, holding both stable until mem_ack; on ack it captures iop=mem_rdata and clears mc_counter.
REQ-014 After FETCH_OP ack, the next state SHALL be FETCH_ARG when NUM_OPS>0, otherwise EXEC; if the captured opcode equals all-ones (HALT opcode), the next state SHALL be HALT regardless.
REQ-015 FETCH_ARG SHALL read rip+1 .. rip+NUM_OPS in order, one ack per word, into ops slots 0..NUM_OPS-1, then go to EXEC.
REQ-016 mem_req SHALL be low outside FETCH_OP/FETCH_ARG; back-to-back requests are permitted, with the address advancing the cycle after each ack.
REQ-017 EXEC SHALL increment mc_counter once per cycle; mc_addr SHALL be combinational from {iop, mc_counter}.
REQ-018 EXEC SHALL end on the cycle mc_finish=1 or mc_counter=all-ones, whichever comes first; the next state is FETCH_OP.
REQ-019 On EXEC end, rip SHALL load br_target if br_take=1, else rip+1+NUM_OPS; br_take SHALL be ignored on all other cycles.
REQ-020 rip arithmetic SHALL wrap modulo 2**ADDR_W, including operand addresses.
REQ-021 HALT SHALL assert hlt=1 with mem_req=0 and all registers frozen until reset.
REQ-022 mem_ack SHALL be ignored while mem_req=0.

Reset
REQ-023 res=0 SHALL immediately clear state=FETCH_OP, rip, iop, ops, mc_counter, hlt and mem_req to 0, abandoning any outstanding fetch or EXEC.
REQ-024 After res rises, the first mem_req SHALL appear on the first clk edge, with mem_addr=0.

Configuration
REQ-025 With GOOFY_SINGLE_STEP_EN defined, the block SHALL add input step (1 bit) and state PAUSE=4, with state widened to 3 bits; EXEC end goes to PAUSE, and PAUSE goes to FETCH_OP on the cycle step=1.
REQ-026 Without GOOFY_SINGLE_STEP_EN, there SHALL be no step port, state SHALL be 2 bits, and EXEC end SHALL go directly to FETCH_OP.

Structure
REQ-027 A shared package goofy_pkg SHALL hold the state enum encodings, the HALT opcode constant and the default parameter values.
REQ-028 The memory fetch handshake (req/addr hold/capture) SHALL be a sub-module goofy_fetch; all other logic is in goofy_seq.

Verification
REQ-029 Zero-wait memory, program {0x01,0xAA,0xBB,...}, mc_finish at step 2: iop=0x01, ops=0xBBAA, EXEC lasts 3 cycles, rip=3.
REQ-030 mem_ack delayed 3 cycles: mem_req and mem_addr are held stable for 4 cycles, then captured data is correct.
REQ-031 mc_finish never asserted, MC_W=3: EXEC lasts exactly 8 cycles (mc_addr low bits 0..7).
REQ-032 br_take=1 and br_target=0x40 on the finish cycle: next mem_addr=0x40; br_take mid-EXEC has no effect.
REQ-033 ADDR_W=8, rip=0xFE, NUM_OPS=2: operands are fetched from 0xFF and 0x00, and next rip=0x01.
REQ-034 Opcode 0xFF fetched: hlt=1 and mem_req=0 indefinitely; res pulsed low mid-fetch: all outputs 0 asynchronously, then refetch from address 0.
